// File: rtl/perif_fifo_send_pack_pkg.sv
// Shared peripheral I/O definitions.
// One-hot write-size encoding and its byte count.
package perif_fifo_send_pack_pkg;

    localparam int SizeB = 0;
    localparam int SizeW = 1;
    localparam int SizeD = 2;
    localparam int SizeQ = 3;

    // Non-one-hot codes map to 0 so callers can treat them as illegal
    function automatic logic [3:0] sizeBytes(input logic [3:0] oneHot);
        logic [3:0] n;
        n = 4'd0;
        case (oneHot)
            4'b0001 << SizeB: n = 4'd1;
            4'b0001 << SizeW: n = 4'd2;
            4'b0001 << SizeD: n = 4'd4;
            4'b0001 << SizeQ: n = 4'd8;
            default:          n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/perif_byte_lane_wr.sv
// Per-entry write enables and rotated data for a
// little-endian multi-byte write into a circular byte array.
module perif_byte_lane_wr #(
    parameter int CAddrLen = 5
) (
    input  logic [CAddrLen-1:0]               AWrPtr,
    input  logic [3:0]                        ALen,
    input  logic [63:0]                       AData,
    output logic [2**CAddrLen-1:0]            AEntWe,
    output logic [2**CAddrLen-1:0][7:0]       AEntData
);

    localparam int Depth = 2**CAddrLen;

    logic [CAddrLen-1:0] off;

    // Offset of each entry from the write pointer picks its source byte
    always_comb begin
        off = '0;
        AEntWe = '0;
        AEntData = '0;
        for (int e = 0; e < Depth; e++) begin
            off = CAddrLen'(e) - AWrPtr;
            AEntWe[e] = off < CAddrLen'(ALen);
            AEntData[e] = AData[off[2:0]*8 +: 8];
        end
    end

endmodule

// File: rtl/perif_fifo_send_pack.sv
// Transmit byte FIFO: multi-byte bus writes in,
// single bytes out to the serial codec.
module perif_fifo_send_pack
    import perif_fifo_send_pack_pkg::*;
#(
    parameter int CAddrLen = 5
) (
    input  logic        AClkH,
    input  logic        AResetHN,
    input  logic        AClkHEn,
    input  logic        AScanI,
    output logic        AScanO,
    input  logic        AScanE,
    input  logic        AResetSN,
    input  logic [63:0] ADataI,
    input  logic [3:0]  AWrSize,
    output logic [7:0]  ADataO,
    input  logic        ARdEn,
    output logic        AHasData,
    output logic        AHasSpace,
    output logic [15:0] AFreeSize,
    output logic        AOvf
);

    localparam int Depth = 2**CAddrLen;
    localparam int FW = CAddrLen + 1;
    localparam int SW = Depth*8 + 3*CAddrLen + 1;

    logic [SW-1:0] stQ;
    logic [SW-1:0] stD;

    logic [Depth-1:0][7:0] FMem;
    logic [CAddrLen-1:0]   FWrPtr;
    logic [CAddrLen-1:0]   FRdPtr;
    logic [FW-1:0]         FFill;

    logic [Depth-1:0][7:0] memD;
    logic [CAddrLen-1:0]   wrD;
    logic [CAddrLen-1:0]   rdD;
    logic [FW-1:0]         fillD;

    logic [3:0]            wrLen;
    logic [FW-1:0]         freeSize;
    logic                  wrReq;
    logic                  wrOk;
    logic                  popOk;
    logic [Depth-1:0]      laneWe;
    logic [Depth-1:0][7:0] laneData;

    // All flops live in one vector so scan shifts straight through it
    assign {FMem, FWrPtr, FRdPtr, FFill} = stQ;
    assign AScanO = stQ[SW-1];

    assign wrLen    = sizeBytes(AWrSize);
    assign wrReq    = |AWrSize;
    assign freeSize = FW'(Depth) - FFill;
    assign wrOk     = (wrLen != 4'd0) && (FW'(wrLen) <= freeSize);
    assign popOk    = ARdEn && (FFill != '0);

    assign AOvf      = AClkHEn && wrReq && !wrOk;
    assign AHasData  = FFill != '0;
    assign AHasSpace = freeSize >= FW'(8);
    assign AFreeSize = 16'(freeSize);
    assign ADataO    = FMem[FRdPtr];

    perif_byte_lane_wr #(
        .CAddrLen (CAddrLen)
    ) uLane (
        .AWrPtr   (FWrPtr),
        .ALen     (wrLen),
        .AData    (ADataI),
        .AEntWe   (laneWe),
        .AEntData (laneData)
    );

    always_comb begin
        memD  = FMem;
        wrD   = FWrPtr;
        rdD   = FRdPtr;
        fillD = FFill;
        if (AClkHEn) begin
            if (!AResetSN) begin
                wrD   = '0;
                rdD   = '0;
                fillD = '0;
            end else begin
                if (wrOk) begin
                    for (int e = 0; e < Depth; e++) begin
                        if (laneWe[e]) memD[e] = laneData[e];
                    end
                    wrD = FWrPtr + CAddrLen'(wrLen);
                end
                if (popOk) rdD = FRdPtr + CAddrLen'(1);
                fillD = FFill + FW'(wrOk ? wrLen : 4'd0)
                      - FW'(popOk);
            end
        end
    end

    always_comb begin
        stD = {memD, wrD, rdD, fillD};
        if (AScanE) stD = {stQ[SW-2:0], AScanI};
    end

    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) stQ <= '0;
        else           stQ <= stD;
    end

endmodule

// File: doc/perif_fifo_send_pack.md
# perif_fifo_send_pack

Transmit-side byte FIFO for the serial peripherals. Accepts 1/2/4/8-byte little-endian writes from the 64-bit peripheral I/O bus and presents one byte at a time to a byte-serial codec, which pops bytes with a single-cycle pick strobe. It sits directly upstream of the SPI codec's send path. It drives that codec's has-data / data inputs and the host-visible free-size and can-write status.

## Interface
- CAddrLen, 5: log2 of depth in bytes (depth = 2^CAddrLen, legal 4..10).
- AClkH  in  1  system clock, all state on rising edge.
- AResetHN  in  1  asynchronous active-low reset.
- AClkHEn  in  1  clock enable; state advances only when 1.
- AScanI / AScanO / AScanE  in/out/in  1  scan chain through all flops.
- AResetSN  in  1  synchronous active-low flush (tied to codec enable).
- ADataI  in  64  write data, byte 0 = ADataI[7:0] sent first.
- AWrSize  in  4  one-hot write size: [0]=1B, [1]=2B, [2]=4B, [3]=8B; all-zero = no write.
- ADataO  out  8  head byte.
- ARdEn  in  1  pop head byte (pick strobe from codec).
- AHasData  out  1  fill ≠ 0.
- AHasSpace  out  1  free ≥ 8, so any write size fits.
- AFreeSize  out  16  free bytes, zero-extended.
- AOvf  out  1  one-cycle pulse: write dropped for lack of space.

## Operation
- State: byte array Mem[2^CAddrLen], write pointer FWrPtr and read pointer FRdPtr (CAddrLen bits, wrap modulo depth), fill count FFill (CAddrLen+1 bits).
- Write size n = 1,2,4,8 from the one-hot AWrSize. A non-one-hot, non-zero AWrSize is treated as no write and pulses AOvf.
- Write accepted iff n ≤ depth − FFill. The pop in the same cycle is not credited.
- Accepted write: Mem[FWrPtr+i] ← ADataI[8i+7:8i] for i<n, with the address wrapping, then FWrPtr += n.
- Rejected write: no state change and AOvf=1 for that cycle. Partial writes never occur.
- Pop: ARdEn & (FFill≠0) → FRdPtr += 1. ARdEn when empty is ignored with no error.
- FFill_next = FFill + (accepted ? n : 0) − (pop ? 1 : 0). Simultaneous write and pop are both applied.
- ADataO = Mem[FRdPtr], combinational from registered state. When empty it holds the stale byte, and consumers gate on AHasData.
- AFreeSize = depth − FFill.
- AResetSN=0 (with AClkHEn=1): pointers and fill go to 0 and Mem is untouched. A write or pop in the same cycle is discarded. Flush has priority.
- AClkHEn=0: no state change. AOvf is forced 0.

## Timing
- After reset: Mem=0, pointers=0, FFill=0, so ADataO=0x00, AHasData=0, AHasSpace=1, AFreeSize=2^CAddrLen, AOvf=0.
- Write in cycle N: AHasData, ADataO and AFreeSize reflect it in N+1.
- Pop in cycle N: next byte appears on ADataO in N+1. Back-to-back pops every cycle are supported.
- AOvf is combinational in the cycle of the offending write.
- A full-depth write sequence ending at FFill=depth gives AHasSpace=0 and AFreeSize=0. A write that fits exactly is accepted.
- Pointer wrap needs no idle cycle. An 8-byte write that straddles the end of the array is written in one cycle.

## Structure
- Shared peripheral package: size one-hot bit indices (SizeB=0, SizeW=1, SizeD=2, SizeQ=3) and a function mapping one-hot to byte count, shared with the receive FIFO and I/O interface decoder.
- Sub-module perif_byte_lane_wr: given FWrPtr, n and ADataI, produces per-entry write-enable and data (rotator plus mask), 2^CAddrLen entries wide.
- Remaining logic is pointers, fill, status and flop list in the top module. Target ≈200 lines.

## Test plan
- Reset, then write 8B 0x0807060504030201 → AFreeSize=24, AHasData=1, ADataO=0x01. Eight pops → bytes 01..08 in order, then AHasData=0, AFreeSize=32.
- Fill with four 8B writes (FFill=32) → AHasSpace=0. A further 1B write → AOvf=1, contents unchanged. Pop one, then write 1B 0xAA → accepted, and 0xAA is the 32nd byte popped.
- Advance pointers to 28 by writing and popping 28 bytes, then write 8B → wraps. Pops return all 8 bytes in order, and FWrPtr=4.
- Same-cycle 4B write and pop at FFill=3 → FFill=6 next cycle. At FFill=29, a 4B write with pop → rejected (AOvf=1) and the pop still happens, so FFill=28.
- AResetSN=0 for one cycle with FFill=10 and a concurrent 2B write → FFill=0 and AFreeSize=32 next cycle. The write is lost.
- AClkHEn=0 while toggling AWrSize and ARdEn → no change in any output. Illegal AWrSize=4'b0011 → AOvf=1, no write.
